// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and write-back grant-source encoding
package cpu_pkg;

  localparam int CPU_ADDR_WIDTH = 5;
  localparam int CPU_DATA_WIDTH = 32;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small power-of-two FIFO buffering load results ahead of write-back
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign full_o       = (cnt_q == CW'(DEPTH));
  assign empty_o      = (cnt_q == '0);
  assign push_ready_o = !full_o;
  assign push         = push_valid_i && !full_o;
  assign pop          = pop_i && !empty_o;
  assign head_data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-back arbiter (ALU vs buffered LSU) with pending scoreboard
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int LSU_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] q_raddr1,
  input  logic [ADDR_WIDTH-1:0] q_raddr2,
  output logic                  q_busy1,
  output logic                  q_busy2
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam int EW    = ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0]         head_ent;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  fifo_empty, fifo_full;
  logic                  grant_alu, grant_lsu;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;

  grant_src_e            last_grant_q, last_grant_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREGS-1:0]      pending_q, pending_d;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (LSU_DEPTH)
  ) u_lsu_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (lsu_valid),
    .push_ready_o (lsu_ready),
    .push_data_i  ({lsu_rd, lsu_data}),
    .pop_i        (grant_lsu),
    .head_data_o  (head_ent),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  assign {head_rd, head_data} = head_ent;

  // alu_ready alone encodes the round-robin decision, so it never looks at alu_valid.
  assign alu_ready = fifo_empty || (last_grant_q == GRANT_LSU);
  assign grant_alu = alu_valid && alu_ready;
  assign grant_lsu = !fifo_empty && !grant_alu;
  assign win_rd    = grant_alu ? alu_rd   : head_rd;
  assign win_data  = grant_alu ? alu_data : head_data;

  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (grant_alu)      last_grant_d = GRANT_ALU;
    else if (grant_lsu) last_grant_d = GRANT_LSU;
    // Writes to x0 are consumed without touching the register file.
    if ((grant_alu || grant_lsu) && (win_rd != '0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = win_rd;
      rf_wdata_d = win_data;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) pending_d[rf_waddr_q] = 1'b0;
    if (iss_valid && (iss_rd != '0)) pending_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_ALU;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pending_q    <= pending_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  assign q_busy1 = pending_q[q_raddr1] && (q_raddr1 != '0) && !(rf_we_q && (rf_waddr_q == q_raddr1));
  assign q_busy2 = pending_q[q_raddr2] && (q_raddr2 != '0) && !(rf_we_q && (rf_waddr_q == q_raddr2));

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, rf_waddr, iss_rd, q_raddr1, q_raddr2;
  logic [31:0] alu_data, lsu_data, rf_wdata;
  logic        rf_we, iss_valid, q_busy1, q_busy2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        lq[$];
  bit          m_last_lsu;
  bit [31:0]   m_pend;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .LSU_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_raddr1(q_raddr1), .q_raddr2(q_raddr2), .q_busy1(q_busy1), .q_busy2(q_busy2)
  );

  function automatic bit e_lsu_ready();
    return lq.size() < DEPTH;
  endfunction

  function automatic bit e_alu_ready();
    return (lq.size() == 0) || m_last_lsu;
  endfunction

  function automatic bit e_busy(input logic [4:0] a);
    return m_pend[a] && (a != 0) && !(m_we && m_waddr == a);
  endfunction

  task automatic model_reset();
    lq.delete();
    m_last_lsu = 0;
    m_pend     = '0;
    m_we       = 0;
    m_waddr    = '0;
    m_wdata    = '0;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    iss_valid = 0; iss_rd = 0;
    q_raddr1  = 0; q_raddr2 = 0;
  endtask

  // Advance one clock: apply the write-back rules to the model, then sample 1 ns after the edge.
  task automatic cycle();
    bit         alu_go, lsu_go, can_push;
    logic [4:0] nrd;
    logic [31:0] nd;
    ent_t       e;
    can_push = e_lsu_ready();
    alu_go   = alu_valid && e_alu_ready();
    lsu_go   = !alu_go && (lq.size() > 0);
    nrd = 0; nd = 0;
    if (alu_go) begin
      nrd = alu_rd; nd = alu_data;
    end else if (lsu_go) begin
      e = lq.pop_front(); nrd = e.rd; nd = e.data;
    end
    if (m_we) m_pend[m_waddr] = 0;
    if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1;
    if (alu_go || lsu_go) m_last_lsu = lsu_go;
    if ((alu_go || lsu_go) && nrd != 0) begin
      m_we = 1; m_waddr = nrd; m_wdata = nd;
    end else begin
      m_we = 0;
    end
    if (lsu_valid && can_push) lq.push_back('{lsu_rd, lsu_data});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    model_reset();
    checks += 5;
    if (rf_we !== 1'b0)     begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    if (rf_waddr !== 5'd0)  begin errors++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    if (lsu_ready !== 1'b1 || alu_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got lsu=%b alu=%b exp 1/1", lsu_ready, alu_ready);
    end
    if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b%b exp=00", q_busy1, q_busy2);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    cycle();
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL release_no_write got=%b exp=0", rf_we); end
  endtask

  task automatic test_alu_only();
    do_reset();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_only_ready got=%b exp=1", alu_ready); end
    cycle();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_only_write got we=%b a=%0d d=%h exp we=1 a=5 d=deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    alu_valid = 0;
    cycle();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_only_hold got we=%b a=%0d d=%h exp we=0 a=5 d=deadbeef", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_contention();
    do_reset();
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h11;
    cycle();
    lsu_valid = 0;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h22;
    #1;
    checks++;
    if (alu_ready !== 1'b0) begin errors++; $display("FAIL contention_alu_ready got=%b exp=0", alu_ready); end
    cycle();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      errors++; $display("FAIL contention_first got we=%b a=%0d d=%h exp we=1 a=3 d=11", rf_we, rf_waddr, rf_wdata);
    end
    cycle();
    alu_valid = 0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin
      errors++; $display("FAIL contention_second got we=%b a=%0d d=%h exp we=1 a=4 d=22", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_backpressure();
    bit saw_full = 0;
    do_reset();
    alu_valid = 1; lsu_valid = 1;
    for (int i = 0; i < 8; i++) begin
      alu_rd = 5'(8 + i); alu_data = 32'hA000 + i;
      lsu_rd = 5'(16 + i); lsu_data = 32'hB000 + i;
      #1;
      checks++;
      if (lsu_ready !== e_lsu_ready() || alu_ready !== e_alu_ready()) begin
        errors++; $display("FAIL bp_ready[%0d] got lsu=%b alu=%b exp lsu=%b alu=%b", i, lsu_ready, alu_ready, e_lsu_ready(), e_alu_ready());
      end
      if (!e_lsu_ready()) saw_full = 1;
      cycle();
      checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        errors++; $display("FAIL bp_write[%0d] got we=%b a=%0d d=%h exp we=%b a=%0d d=%h", i, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
    end
    checks++;
    if (!saw_full) begin errors++; $display("FAIL bp_reached_full got=0 exp=1"); end
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();
  endtask

  task automatic test_scoreboard();
    do_reset();
    q_raddr1 = 7; q_raddr2 = 0;
    iss_valid = 1; iss_rd = 7;
    cycle();
    iss_valid = 0;
    #1;
    checks += 2;
    if (q_busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy_after_issue got=%b exp=1", q_busy1); end
    if (q_busy2 !== 1'b0) begin errors++; $display("FAIL sb_busy_rd0 got=%b exp=0", q_busy2); end
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    cycle();
    alu_valid = 0;
    #1;
    checks++;
    if (rf_we !== 1'b1 || q_busy1 !== 1'b0) begin
      errors++; $display("FAIL sb_bypass got we=%b busy=%b exp we=1 busy=0", rf_we, q_busy1);
    end
    iss_valid = 1; iss_rd = 7;
    cycle();
    iss_valid = 0;
    #1;
    checks++;
    if (q_busy1 !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%b exp=1", q_busy1); end
  endtask

  task automatic test_rd0();
    logic [31:0] prev;
    do_reset();
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    cycle();
    prev = rf_wdata;
    alu_rd = 0; alu_data = 32'h55;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got=%b exp=1", alu_ready); end
    cycle();
    alu_valid = 0;
    checks++;
    if (rf_we !== 1'b0 || rf_wdata !== 32'h99) begin
      errors++; $display("FAIL rd0_no_write got we=%b d=%h exp we=0 d=99 (prev %h)", rf_we, rf_wdata, prev);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alu_valid = 1; lsu_valid = 1; iss_valid = 1;
    for (int i = 0; i < 3; i++) begin
      alu_rd = 5'(10 + i); alu_data = 32'hC0 + i;
      lsu_rd = 5'(20 + i); lsu_data = 32'hD0 + i;
      iss_rd = 5'(1 + i);
      cycle();
    end
    idle_inputs();
    q_raddr1 = 1; q_raddr2 = 2;
    #1;
    checks++;
    if (lsu_ready !== 1'b0) begin errors++; $display("FAIL mid_full_before got=%b exp=0", lsu_ready); end
    #2;
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (rf_we !== 1'b0 || lsu_ready !== 1'b1 || q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin
      errors++; $display("FAIL mid_reset got we=%b lsu_ready=%b busy=%b%b exp 0/1/00", rf_we, lsu_ready, q_busy1, q_busy2);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_stale_write[%0d] got=%b exp=0", i, rf_we); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      alu_valid = ($urandom_range(0, 2) != 0);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      lsu_valid = ($urandom_range(0, 1) != 0);
      lsu_rd    = 5'($urandom_range(0, 7));
      lsu_data  = $urandom;
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd    = 5'($urandom_range(0, 7));
      q_raddr1  = 5'($urandom_range(0, 7));
      q_raddr2  = 5'($urandom_range(0, 7));
      #1;
      checks++;
      if (lsu_ready !== e_lsu_ready() || alu_ready !== e_alu_ready() ||
          q_busy1 !== e_busy(q_raddr1) || q_busy2 !== e_busy(q_raddr2)) begin
        errors++;
        $display("FAIL rand_comb[%0d] got lsu=%b alu=%b b1=%b b2=%b exp lsu=%b alu=%b b1=%b b2=%b", i,
                 lsu_ready, alu_ready, q_busy1, q_busy2, e_lsu_ready(), e_alu_ready(), e_busy(q_raddr1), e_busy(q_raddr2));
      end
      cycle();
      checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        errors++; $display("FAIL rand_write[%0d] got we=%b a=%0d d=%h exp we=%b a=%0d d=%h", i, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1;
    #2;
    test_reset();
    test_alu_only();
    test_contention();
    test_backpressure();
    test_scoreboard();
    test_rd0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
